// File: rtl/npu_pkg.sv
// Shared defaults and FSM state encoding for the NPU output write-back stage.
package npu_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int MAC_IN_NUM  = 9;
  localparam int MAC_OUT_NUM = 18;
  localparam int ADDR_WIDTH  = 16;
  localparam int FIFO_DEPTH  = 8;

  // Write-back sequencing: two beats per result vector, then a one-cycle finish.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    FIN   = 2'd3
  } wrState_e;

endpackage

// File: rtl/npu_out_writer_if.sv
// Valid/ready memory-write port into the output feature-map buffer.
interface npu_out_writer_if #(
  parameter int ADDR_WIDTH = npu_pkg::ADDR_WIDTH,
  parameter int WORD_WIDTH = npu_pkg::MAC_IN_NUM * npu_pkg::DATA_WIDTH
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/npu_out_fifo.sv
// First-word-fall-through FIFO holding complete core result vectors.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module npu_out_fifo #(
  parameter int WIDTH = npu_pkg::MAC_OUT_NUM * npu_pkg::DATA_WIDTH,
  parameter int DEPTH = npu_pkg::FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush;
  logic             doPop;

  assign full   = (count_q == (PTR_W+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem_q[rdPtr_q];
  assign count  = count_q;

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= din;
    end
  end

  // Pointers and occupancy; flush discards everything including a same-cycle push.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      count_q <= count_q + (PTR_W+1)'(doPush) - (PTR_W+1)'(doPop);
    end
  end

endmodule

// File: rtl/npu_out_writer.sv
// Write-back stage: buffers non-stallable core result vectors and writes each
// as two half-vector beats, one per channel-group plane.
module npu_out_writer #(
  parameter int MAC_OUT_NUM = npu_pkg::MAC_OUT_NUM,
  parameter int MAC_IN_NUM  = npu_pkg::MAC_IN_NUM,
  parameter int DATA_WIDTH  = npu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = npu_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH  = npu_pkg::FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [MAC_OUT_NUM*DATA_WIDTH-1:0] core_data_in,
  input  logic                              core_valid_in,
  input  logic                              cfg_start,
  input  logic [ADDR_WIDTH-1:0]             cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]             cfg_plane_stride,
  input  logic [15:0]                       cfg_pix_num,
  npu_out_writer_if.master                  wr,
  output logic                              stall_req,
  output logic                              busy,
  output logic                              done,
  output logic                              err_overflow,
  output logic                              err_unexpected
);

  import npu_pkg::*;

  localparam int VEC_W  = MAC_OUT_NUM * DATA_WIDTH;
  localparam int HALF_W = MAC_IN_NUM * DATA_WIDTH;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  wrState_e              state_q;
  wrState_e              state_d;
  logic [15:0]           pixCnt_q;
  logic [15:0]           pixCnt_d;
  logic [15:0]           pixNum_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic                  errOverflow_q;
  logic                  errUnexpected_q;
  logic                  stallReq_q;

  logic                  wrValid;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [HALF_W-1:0]     wrData;

  logic                  fifoPush;
  logic                  fifoPop;
  logic                  fifoFlush;
  logic                  pushAccept;
  logic                  overflowEvt;
  logic [VEC_W-1:0]      fifoDout;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [CNT_W-1:0]      fifoCount;
  logic [CNT_W-1:0]      fifoCountNext;

  npu_out_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (fifoFlush),
    .push  (fifoPush),
    .pop   (fifoPop),
    .din   (core_data_in),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // The core cannot stall, so every vector arriving mid-tile is offered to the FIFO.
  assign fifoPush    = core_valid_in && (state_q != IDLE);
  assign pushAccept  = fifoPush && (!fifoFull || fifoPop);
  assign overflowEvt = fifoPush && fifoFull && !fifoPop;

  // Next-state, beat selection and address generation; the head stays put until BEAT1 completes.
  always_comb begin
    state_d   = state_q;
    pixCnt_d  = pixCnt_q;
    wrValid   = 1'b0;
    wrAddr    = '0;
    wrData    = '0;
    fifoPop   = 1'b0;
    fifoFlush = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          pixCnt_d = '0;
          state_d  = (cfg_pix_num == 16'd0) ? FIN : BEAT0;
        end
      end
      BEAT0: begin
        wrValid = !fifoEmpty;
        if (wrValid) begin
          wrData = fifoDout[HALF_W-1:0];
          wrAddr = base_q + ADDR_WIDTH'(pixCnt_q);
        end
        if (wrValid && wr.wr_ready) begin
          state_d = BEAT1;
        end
      end
      BEAT1: begin
        wrValid = 1'b1;
        wrData  = fifoDout[HALF_W +: HALF_W];
        wrAddr  = base_q + stride_q + ADDR_WIDTH'(pixCnt_q);
        if (wr.wr_ready) begin
          fifoPop  = 1'b1;
          pixCnt_d = pixCnt_q + 16'd1;
          state_d  = (pixCnt_q == pixNum_q - 16'd1) ? FIN : BEAT0;
        end
      end
      FIN: begin
        fifoFlush = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy after this cycle, so stall_req lands one cycle after the push that caused it.
  always_comb begin
    fifoCountNext = '0;
    if (!fifoFlush) begin
      fifoCountNext = fifoCount + CNT_W'(pushAccept) - CNT_W'(fifoPop);
    end
  end

  // State, tile configuration and pixel counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      pixCnt_q <= '0;
      pixNum_q <= '0;
      base_q   <= '0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      pixCnt_q <= pixCnt_d;
      if (state_q == IDLE && cfg_start) begin
        pixNum_q <= cfg_pix_num;
        base_q   <= cfg_base_addr;
        stride_q <= cfg_plane_stride;
      end
    end
  end

  // Sticky error flags (cleared by a new tile) and the registered stall request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      errOverflow_q   <= 1'b0;
      errUnexpected_q <= 1'b0;
      stallReq_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && cfg_start) begin
        errOverflow_q   <= 1'b0;
        errUnexpected_q <= 1'b0;
      end
      if (overflowEvt) begin
        errOverflow_q <= 1'b1;
      end
      if (state_q == IDLE && core_valid_in) begin
        errUnexpected_q <= 1'b1;
      end
      stallReq_q <= (fifoCountNext >= CNT_W'(FIFO_DEPTH - 2));
    end
  end

  assign wr.wr_valid    = wrValid;
  assign wr.wr_addr     = wrAddr;
  assign wr.wr_data     = wrData;
  assign stall_req      = stallReq_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FIN);
  assign err_overflow   = errOverflow_q;
  assign err_unexpected = errUnexpected_q;

endmodule

// File: tb/tb_npu_out_writer.sv
// Self-checking bench for npu_out_writer: a vector-queue scoreboard watches every
// cycle while table-driven tiles, hand-written corner sequences and random tiles run.
module tb_npu_out_writer;

  import npu_pkg::*;

  localparam int DEPTH = 8;
  localparam int VW    = MAC_OUT_NUM * DATA_WIDTH;
  localparam int HW    = MAC_IN_NUM * DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rstn;
  logic [VW-1:0] coreData;
  logic          coreValid;
  logic          cfgStart;
  logic [15:0]   cfgBase;
  logic [15:0]   cfgStride;
  logic [15:0]   cfgPixNum;
  logic          stallReq;
  logic          busy;
  logic          done;
  logic          errOverflow;
  logic          errUnexpected;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  npu_out_writer_if #(.ADDR_WIDTH(16), .WORD_WIDTH(HW)) wrIf ();

  npu_out_writer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .core_data_in     (coreData),
    .core_valid_in    (coreValid),
    .cfg_start        (cfgStart),
    .cfg_base_addr    (cfgBase),
    .cfg_plane_stride (cfgStride),
    .cfg_pix_num      (cfgPixNum),
    .wr               (wrIf),
    .stall_req        (stallReq),
    .busy             (busy),
    .done             (done),
    .err_overflow     (errOverflow),
    .err_unexpected   (errUnexpected)
  );

  task automatic checkOutput(input string name, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model state: tile config, accepted vectors in order, beat position.
  bit          modelOn = 1'b0;
  logic [VW-1:0] vecQ[$];
  logic [15:0] addrLog[$];
  bit          mBusy, mDone, mOv, mUn, mStall, mHold, mBeat;
  logic [15:0] mBase, mStride, mPixNum, mPixIdx;
  logic [15:0] holdAddr;
  logic [HW-1:0] holdData;
  int          writes = 0;
  int          doneCount = 0;
  bit          stallSeen;

  // Mid-cycle scoreboard: compare this cycle's outputs, then advance the model.
  always @(negedge clk) begin
    logic          expValid;
    logic [15:0]   expAddr;
    logic [VW-1:0] head;
    bit            nextDone;
    bit            nextBusy;
    if (modelOn) begin
      checkOutput("busy", busy, mBusy);
      checkOutput("done", done, mDone);
      checkOutput("err_overflow", errOverflow, mOv);
      checkOutput("err_unexpected", errUnexpected, mUn);
      checkOutput("stall_req", stallReq, mStall);
      expValid = mBusy && !mDone && (vecQ.size() > 0);
      checkOutput("wr_valid", wrIf.wr_valid, expValid);
      if (mHold) begin
        checkOutput("hold_addr", wrIf.wr_addr, holdAddr);
        checkOutput("hold_data", wrIf.wr_data, holdData);
      end
      if (expValid && wrIf.wr_valid) begin
        head    = vecQ[0];
        expAddr = mBase + (mBeat ? mStride : 16'd0) + mPixIdx;
        checkOutput("wr_addr", wrIf.wr_addr, expAddr);
        checkOutput("wr_data", wrIf.wr_data, mBeat ? head[VW-1:HW] : head[HW-1:0]);
      end
      if (done) doneCount++;
      if (!rstn) begin
        vecQ.delete();
        mBusy = 0; mDone = 0; mOv = 0; mUn = 0; mStall = 0; mHold = 0; mBeat = 0;
        mPixIdx = '0;
      end else begin
        nextDone = 0;
        nextBusy = mBusy && !mDone;
        if (wrIf.wr_valid && wrIf.wr_ready && expValid) begin
          writes++;
          addrLog.push_back(wrIf.wr_addr);
          if (mBeat) begin
            void'(vecQ.pop_front());
            mPixIdx = mPixIdx + 16'd1;
            mBeat   = 0;
            if (mPixIdx == mPixNum) nextDone = 1;
          end else begin
            mBeat = 1;
          end
        end
        if (!mBusy && cfgStart) begin
          mBase = cfgBase; mStride = cfgStride; mPixNum = cfgPixNum;
          mOv = 0; mUn = 0; mPixIdx = '0; mBeat = 0;
          nextBusy = 1;
          if (cfgPixNum == 16'd0) nextDone = 1;
        end
        if (coreValid) begin
          if (!mBusy) mUn = 1;
          else if (vecQ.size() < DEPTH) vecQ.push_back(coreData);
          else mOv = 1;
        end
        if (mDone) vecQ.delete();
        mHold    = wrIf.wr_valid && !wrIf.wr_ready;
        holdAddr = wrIf.wr_addr;
        holdData = wrIf.wr_data;
        mBusy    = nextBusy;
        mDone    = nextDone;
        mStall   = (vecQ.size() >= DEPTH - 2);
        if (stallReq) stallSeen = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then advance to just after the next edge.
  task automatic applyStimulus(input bit start, input bit valid, input logic [VW-1:0] data, input bit ready);
    cfgStart       = start;
    coreValid      = valid;
    coreData       = data;
    wrIf.wr_ready  = ready;
    tick();
  endtask

  function automatic logic [VW-1:0] makeVec(input bit ramp);
    logic [VW-1:0] v;
    for (int i = 0; i < MAC_OUT_NUM; i++) begin
      v[i*8 +: 8] = ramp ? 8'(i) : 8'($urandom);
    end
    return v;
  endfunction

  typedef struct {
    logic [15:0] base;
    logic [15:0] stride;
    logic [15:0] pixNum;
    int          nVec;
    int          lowCycles;
    bit          ramp;
    bit          expOv;
    int          expWrites;
    bit          expStall;
    int          probeIdx;
    logic [15:0] probeAddr;
  } tileVec_t;

  tileVec_t vecs[5];

  task automatic waitDone(input int doneRef, input int limit);
    int n = 0;
    while (doneCount == doneRef && n < limit) begin
      applyStimulus(0, 0, '0, 1);
      n++;
    end
  endtask

  task automatic runTile(input tileVec_t v);
    int w0 = writes;
    int d0 = doneCount;
    int n  = (v.nVec > v.lowCycles) ? v.nVec : v.lowCycles;
    addrLog.delete();
    stallSeen = 0;
    cfgBase = v.base; cfgStride = v.stride; cfgPixNum = v.pixNum;
    applyStimulus(1, 0, '0, v.lowCycles == 0);
    for (int k = 0; k < n; k++) begin
      applyStimulus(0, k < v.nVec, makeVec(v.ramp), k >= v.lowCycles);
    end
    waitDone(d0, 200);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("tile_writes", writes - w0, v.expWrites);
    checkOutput("tile_done_pulses", doneCount - d0, 1);
    checkOutput("tile_err_overflow", errOverflow, v.expOv);
    checkOutput("tile_err_unexpected", errUnexpected, 0);
    checkOutput("tile_stall_seen", stallSeen, v.expStall);
    if (v.probeIdx >= 0) begin
      if (addrLog.size() > v.probeIdx) checkOutput("tile_probe_addr", addrLog[v.probeIdx], v.probeAddr);
      else checkOutput("tile_probe_count", addrLog.size(), v.probeIdx + 1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    int d0;
    int pushed;
    int cyc;
    int pix;

    //                base     stride   pix    nVec low ramp ov writes stall probe addr
    vecs[0] = '{16'h0100, 16'h0040, 16'd1, 1,  0,  1, 0, 2,  0, 1,  16'h0140};
    vecs[1] = '{16'h0100, 16'h0040, 16'd4, 4,  0,  0, 0, 8,  0, 7,  16'h0143};
    vecs[2] = '{16'h0200, 16'h0080, 16'd8, 10, 20, 0, 1, 16, 1, 15, 16'h0287};
    vecs[3] = '{16'hFFFF, 16'h0010, 16'd2, 2,  0,  0, 0, 4,  0, 2,  16'h0000};
    vecs[4] = '{16'h0100, 16'h0040, 16'd0, 0,  0,  0, 0, 0,  0, -1, 16'h0000};

    rstn = 0; cfgStart = 0; coreValid = 0; coreData = '0;
    cfgBase = '0; cfgStride = '0; cfgPixNum = '0; wrIf.wr_ready = 0;
    tick();
    modelOn = 1;
    tick();
    tick();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wr_valid", wrIf.wr_valid, 0);
    rstn = 1;
    tick();

    $display("[TB] core_valid_in while idle");
    w0 = writes;
    applyStimulus(0, 1, makeVec(0), 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("idle_err_unexpected", errUnexpected, 1);
    checkOutput("idle_no_write", writes - w0, 0);

    $display("[TB] table-driven tiles");
    for (int i = 0; i < 5; i++) begin
      runTile(vecs[i]);
    end

    $display("[TB] full FIFO with push and BEAT1 pop in the same cycle");
    w0 = writes; d0 = doneCount;
    cfgBase = 16'h0300; cfgStride = 16'h0020; cfgPixNum = 16'd9;
    applyStimulus(1, 0, '0, 0);
    for (int k = 0; k < DEPTH; k++) applyStimulus(0, 1, makeVec(0), 0);
    applyStimulus(0, 0, '0, 0);
    applyStimulus(0, 0, '0, 0);
    checkOutput("full_stall_req", stallReq, 1);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 1, makeVec(0), 1);
    waitDone(d0, 200);
    applyStimulus(0, 0, '0, 1);
    checkOutput("full_pop_err_overflow", errOverflow, 0);
    checkOutput("full_pop_writes", writes - w0, 18);

    $display("[TB] reset in the middle of a tile");
    d0 = doneCount;
    cfgBase = 16'h0400; cfgStride = 16'h0040; cfgPixNum = 16'd4;
    applyStimulus(1, 0, '0, 0);
    for (int k = 0; k < DEPTH + 1; k++) applyStimulus(0, 1, makeVec(0), 0);
    checkOutput("pre_reset_overflow", errOverflow, 1);
    rstn = 0;
    applyStimulus(0, 0, '0, 0);
    rstn = 1;
    checkOutput("rst_wr_valid", wrIf.wr_valid, 0);
    checkOutput("rst_wr_addr", wrIf.wr_addr, 0);
    checkOutput("rst_wr_data", wrIf.wr_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_stall_req", stallReq, 0);
    checkOutput("rst_err_overflow", errOverflow, 0);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("rst_no_done", doneCount - d0, 0);
    w0 = writes;
    cfgBase = 16'h0500; cfgPixNum = 16'd1;
    applyStimulus(1, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("rst_fifo_empty", wrIf.wr_valid, 0);
    applyStimulus(0, 1, makeVec(1), 1);
    waitDone(d0, 50);
    applyStimulus(0, 0, '0, 1);
    checkOutput("rst_restart_writes", writes - w0, 2);
    checkOutput("rst_restart_done", doneCount - d0, 1);

    $display("[TB] random tiles with a well-behaved upstream");
    for (int t = 0; t < 6; t++) begin
      w0 = writes; d0 = doneCount;
      pix = $urandom_range(1, 12);
      cfgBase = 16'($urandom); cfgStride = 16'($urandom); cfgPixNum = 16'(pix);
      applyStimulus(1, 0, '0, 1);
      pushed = 0; cyc = 0;
      while (doneCount == d0 && cyc < 2000) begin
        if (pushed < pix && !stallReq && $urandom_range(0, 9) < 6) begin
          applyStimulus(0, 1, makeVec(0), $urandom_range(0, 9) < 7);
          pushed++;
        end else begin
          applyStimulus(0, 0, '0, $urandom_range(0, 9) < 7);
        end
        cyc++;
      end
      applyStimulus(0, 0, '0, 1);
      checkOutput("rand_writes", writes - w0, 2 * pix);
      checkOutput("rand_done", doneCount - d0, 1);
      checkOutput("rand_err_overflow", errOverflow, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
